// File: rtl/inst_mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single-ported instruction/data memory.
// Data has priority, bounded by a starvation streak; accesses are rejected when misaligned and aborted on timeout.
module inst_mem_arbiter #(
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int SW = $clog2(STREAK_MAX + 2);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);
    localparam logic [TW-1:0] TIMER_TOP  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t      state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        misalign_q, misalign_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;

    logic        busy, expired, done, fail, fetch_wins;
    logic [31:0] rd_val, grant_addr;

    // A real mem_ready in the expiry cycle still wins: only an unanswered expiry is a failure.
    always_comb begin
        busy    = (state_q != IDLE);
        expired = mem_req_q && (timer_q == TIMER_TOP);
        done    = busy && (misalign_q || mem_ready || expired);
        fail    = misalign_q || (expired && !mem_ready);
        rd_val  = (fail || mem_we_q) ? 32'd0 : mem_rdata;
    end

    assign if_ready  = !rst && done && (state_q == BUSY_IF);
    assign dm_ready  = !rst && done && (state_q == BUSY_DM);
    assign err       = !rst && done && fail;
    assign if_rdata  = if_ready ? rd_val : if_rdata_q;
    assign dm_rdata  = dm_ready ? rd_val : dm_rdata_q;
    assign mem_req   = mem_req_q && !mem_ready && !expired;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        // NOTE: every _d gets a default here, so no path through the case can infer a latch.
        state_d     = state_q;
        streak_d    = streak_q;
        timer_d     = timer_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        misalign_d  = misalign_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        fetch_wins = if_req && (!dm_req || streak_q == STREAK_TOP);
        grant_addr = fetch_wins ? if_addr : dm_addr;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d     = fetch_wins ? BUSY_IF : BUSY_DM;
                    mem_addr_d  = {2'b00, grant_addr[31:2]};
                    mem_we_d    = !fetch_wins && dm_we;
                    mem_wdata_d = fetch_wins ? 32'd0 : dm_wdata;
                    misalign_d  = (grant_addr[1:0] != 2'b00);
                    mem_req_d   = (grant_addr[1:0] == 2'b00);
                    timer_d     = '0;
                    if (fetch_wins || !if_req)
                        streak_d = '0;
                    else if (streak_q != STREAK_TOP)
                        streak_d = streak_q + 1'b1;
                end
            end
            default: begin
                if (done) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    misalign_d = 1'b0;
                    timer_d    = '0;
                    if (state_q == BUSY_IF)
                        if_rdata_d = rd_val;
                    else
                        dm_rdata_d = rd_val;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            timer_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            misalign_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            timer_q     <= timer_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            misalign_q  <= misalign_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end
endmodule
